cmp_branch_sched: RTL and testbench

- Shares the single 16-bit signed register comparator between two requesters: normal-context branch unit (N) and interrupt-context branch unit (I).
- Per request: arbitrate, issue the compare with the requester's context flag, wait for the registered flags, evaluate a 3-bit condition code, return taken/not-taken plus branch target.
- Sits between the branch decode logic and the comparator, and is the comparator's only driver.

---
 rtl/cmp_branch_sched_if.sv | 68 ++++++
 rtl/cmp_branch_sched.sv | 270 +++++++++++++++++++++++++++
 tb/tb_cmp_branch_sched.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_branch_sched_if.sv
// ----------------------------------------------------------------------------
// cmp_branch_sched_if
//   Bundles every non-clock/reset signal of the branch scheduler: the two
//   requester channels (normal N, interrupt I), the comparator drive/flag
//   lines and the response/status outputs.
//
//   Modports:
//     master : requesters + comparator side (drives requests and flags,
//              observes acks, comparator drive and responses)
//     slave  : the scheduler itself
//
//   Parameter AW : branch target width.
// ----------------------------------------------------------------------------
interface cmp_branch_sched_if #(
  parameter int AW = 16
);

  // Normal-context requester
  logic          n_req;
  logic [1:0]    n_num1;
  logic [1:0]    n_num2;
  logic [2:0]    n_cond;
  logic [AW-1:0] n_target;
  logic          n_ack;

  // Interrupt-context requester
  logic          i_req;
  logic [1:0]    i_num1;
  logic [1:0]    i_num2;
  logic [2:0]    i_cond;
  logic [AW-1:0] i_target;
  logic          i_ack;

  // Comparator drive and flags
  logic          cmp_start;
  logic          cmp_inter;
  logic [1:0]    cmp_num1;
  logic [1:0]    cmp_num2;
  logic          cmp_lt;
  logic          cmp_gt;
  logic          cmp_eq;

  // Response and status
  logic          resp_valid;
  logic          resp_ctx;
  logic          resp_taken;
  logic [AW-1:0] resp_target;
  logic          busy;

  modport master (
    output n_req, n_num1, n_num2, n_cond, n_target,
    output i_req, i_num1, i_num2, i_cond, i_target,
    output cmp_lt, cmp_gt, cmp_eq,
    input  n_ack, i_ack,
    input  cmp_start, cmp_inter, cmp_num1, cmp_num2,
    input  resp_valid, resp_ctx, resp_taken, resp_target, busy
  );

  modport slave (
    input  n_req, n_num1, n_num2, n_cond, n_target,
    input  i_req, i_num1, i_num2, i_cond, i_target,
    input  cmp_lt, cmp_gt, cmp_eq,
    output n_ack, i_ack,
    output cmp_start, cmp_inter, cmp_num1, cmp_num2,
    output resp_valid, resp_ctx, resp_taken, resp_target, busy
  );

endinterface

// File: rtl/cmp_branch_sched.sv
// ----------------------------------------------------------------------------
// cmp_branch_sched
//   Shares one 16-bit signed register comparator between a normal-context
//   branch unit (N) and an interrupt-context branch unit (I). Each request is
//   arbitrated, issued to the comparator with its context flag, the
//   registered flags are evaluated against a 3-bit condition code and a
//   taken/not-taken result is returned with the latched branch target.
//
//   Ports:
//     clk  : clock
//     rst  : asynchronous, active-high reset
//     bus  : cmp_branch_sched_if.slave
//            n_* / i_*      requester channels (req held until ack)
//            cmp_*          comparator drive (start, ctx, operand selects)
//                           and registered, context-muxed flags
//            resp_*         one-cycle result pulse with ctx/taken/target
//            busy           high whenever the sequencer is not idle
//
//   Parameters:
//     AW             : branch target width
//     INT_STREAK_MAX : max consecutive I grants while N waits (1..15)
//
//   Optional feature (macro CMP_BYPASS_EN):
//     When defined, condition codes ALWAYS/NEVER skip the comparator and
//     respond in the grant cycle (ack and resp_valid together).
//     When undefined, every condition code takes the full compare path.
//
//   Latency (compare path): request sampled at edge t, ack in cycle t+1,
//   resp_valid in cycle t+3; one operation per 4 cycles.
// ----------------------------------------------------------------------------
module cmp_branch_sched #(
  parameter int AW             = 16,
  parameter int INT_STREAK_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  cmp_branch_sched_if.slave  bus
);

  localparam logic [3:0] STREAK_MAX = INT_STREAK_MAX[3:0];

  localparam logic [2:0] COND_EQ     = 3'd0;
  localparam logic [2:0] COND_NE     = 3'd1;
  localparam logic [2:0] COND_LT     = 3'd2;
  localparam logic [2:0] COND_GT     = 3'd3;
  localparam logic [2:0] COND_LE     = 3'd4;
  localparam logic [2:0] COND_GE     = 3'd5;
  localparam logic [2:0] COND_ALWAYS = 3'd6;
  localparam logic [2:0] COND_NEVER  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_EVAL  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Condition-code evaluation against the comparator flags.
  function automatic logic cond_eval(
    input logic [2:0] cond,
    input logic       lt,
    input logic       gt,
    input logic       eq
  );
    logic res;
    case (cond)
      COND_EQ:     res = eq;
      COND_NE:     res = ~eq;
      COND_LT:     res = lt;
      COND_GT:     res = gt;
      COND_LE:     res = lt | eq;
      COND_GE:     res = gt | eq;
      COND_ALWAYS: res = 1'b1;
      COND_NEVER:  res = 1'b0;
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

  // Sequencer state and latched request
  state_t        state_r;
  logic          ctx_r;
  logic [2:0]    cond_r;
  logic [AW-1:0] target_r;
  logic [3:0]    streak_r;

  // Registered outputs
  logic          n_ack_r;
  logic          i_ack_r;
  logic          cmp_start_r;
  logic          cmp_inter_r;
  logic [1:0]    cmp_num1_r;
  logic [1:0]    cmp_num2_r;
  logic          resp_valid_r;
  logic          resp_ctx_r;
  logic          resp_taken_r;
  logic [AW-1:0] resp_target_r;
  logic          busy_r;

  // Arbitration result for the current cycle (only used in IDLE)
  logic          any_req_s;
  logic          grant_n_s;
  logic          sel_ctx_s;
  logic [1:0]    sel_num1_s;
  logic [1:0]    sel_num2_s;
  logic [2:0]    sel_cond_s;
  logic [AW-1:0] sel_target_s;
  logic [3:0]    streak_nxt_s;
  logic          bypass_s;

  // Arbitration: I wins unless it is idle or N has waited out the streak.
  always_comb begin
    any_req_s    = bus.n_req | bus.i_req;
    grant_n_s    = 1'b0;
    sel_ctx_s    = 1'b0;
    sel_num1_s   = 2'd0;
    sel_num2_s   = 2'd0;
    sel_cond_s   = 3'd0;
    sel_target_s = {AW{1'b0}};
    streak_nxt_s = streak_r;
    bypass_s     = 1'b0;

    if (bus.n_req && (!bus.i_req || (streak_r == STREAK_MAX))) begin
      grant_n_s = 1'b1;
    end else begin
      grant_n_s = 1'b0;
    end

    if (grant_n_s) begin
      sel_ctx_s    = 1'b0;
      sel_num1_s   = bus.n_num1;
      sel_num2_s   = bus.n_num2;
      sel_cond_s   = bus.n_cond;
      sel_target_s = bus.n_target;
      streak_nxt_s = 4'd0;
    end else begin
      sel_ctx_s    = 1'b1;
      sel_num1_s   = bus.i_num1;
      sel_num2_s   = bus.i_num2;
      sel_cond_s   = bus.i_cond;
      sel_target_s = bus.i_target;
      // The streak only counts I grants that made a waiting N wait longer.
      if (bus.n_req) begin
        if (streak_r >= STREAK_MAX) begin
          streak_nxt_s = STREAK_MAX;
        end else begin
          streak_nxt_s = streak_r + 4'd1;
        end
      end else begin
        streak_nxt_s = 4'd0;
      end
    end

`ifdef CMP_BYPASS_EN
    bypass_s = (sel_cond_s == COND_ALWAYS) || (sel_cond_s == COND_NEVER);
`else
    bypass_s = 1'b0;
`endif
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      ctx_r         <= 1'b0;
      cond_r        <= 3'd0;
      target_r      <= {AW{1'b0}};
      streak_r      <= 4'd0;
      n_ack_r       <= 1'b0;
      i_ack_r       <= 1'b0;
      cmp_start_r   <= 1'b0;
      cmp_inter_r   <= 1'b0;
      cmp_num1_r    <= 2'd0;
      cmp_num2_r    <= 2'd0;
      resp_valid_r  <= 1'b0;
      resp_ctx_r    <= 1'b0;
      resp_taken_r  <= 1'b0;
      resp_target_r <= {AW{1'b0}};
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            ctx_r       <= sel_ctx_s;
            cond_r      <= sel_cond_s;
            target_r    <= sel_target_s;
            streak_r    <= streak_nxt_s;
            n_ack_r     <= grant_n_s;
            i_ack_r     <= ~grant_n_s;
            cmp_inter_r <= sel_ctx_s;
            cmp_num1_r  <= sel_num1_s;
            cmp_num2_r  <= sel_num2_s;
            busy_r      <= 1'b1;
            if (bypass_s) begin
              // Result is known without the comparator; flags stay untouched.
              state_r       <= ST_RESP;
              cmp_start_r   <= 1'b0;
              resp_valid_r  <= 1'b1;
              resp_ctx_r    <= sel_ctx_s;
              resp_taken_r  <= cond_eval(sel_cond_s, 1'b0, 1'b0, 1'b0);
              resp_target_r <= sel_target_s;
            end else begin
              state_r       <= ST_ISSUE;
              cmp_start_r   <= 1'b1;
              resp_valid_r  <= 1'b0;
            end
          end else begin
            state_r      <= ST_IDLE;
            n_ack_r      <= 1'b0;
            i_ack_r      <= 1'b0;
            cmp_start_r  <= 1'b0;
            cmp_inter_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
          end
        end

        ST_ISSUE: begin
          // cmp_inter stays at ctx so EVAL sees this context's flag bank.
          state_r     <= ST_EVAL;
          n_ack_r     <= 1'b0;
          i_ack_r     <= 1'b0;
          cmp_start_r <= 1'b0;
        end

        ST_EVAL: begin
          state_r       <= ST_RESP;
          resp_valid_r  <= 1'b1;
          resp_ctx_r    <= ctx_r;
          resp_taken_r  <= cond_eval(cond_r, bus.cmp_lt, bus.cmp_gt, bus.cmp_eq);
          resp_target_r <= target_r;
        end

        ST_RESP: begin
          // Requests are deliberately not sampled here.
          state_r      <= ST_IDLE;
          n_ack_r      <= 1'b0;
          i_ack_r      <= 1'b0;
          cmp_start_r  <= 1'b0;
          cmp_inter_r  <= 1'b0;
          resp_valid_r <= 1'b0;
          busy_r       <= 1'b0;
        end

        default: begin
          state_r      <= ST_IDLE;
          n_ack_r      <= 1'b0;
          i_ack_r      <= 1'b0;
          cmp_start_r  <= 1'b0;
          cmp_inter_r  <= 1'b0;
          resp_valid_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.n_ack       = n_ack_r;
  assign bus.i_ack       = i_ack_r;
  assign bus.cmp_start   = cmp_start_r;
  assign bus.cmp_inter   = cmp_inter_r;
  assign bus.cmp_num1    = cmp_num1_r;
  assign bus.cmp_num2    = cmp_num2_r;
  assign bus.resp_valid  = resp_valid_r;
  assign bus.resp_ctx    = resp_ctx_r;
  assign bus.resp_taken  = resp_taken_r;
  assign bus.resp_target = resp_target_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_cmp_branch_sched.sv
// ----------------------------------------------------------------------------
// tb_cmp_branch_sched
//   Self-checking bench for cmp_branch_sched. Contains a model of the shared
//   comparator (two register banks, registered flags per context, flags
//   muxed by cmp_inter) and computes expected branch outcomes directly from
//   the signed operand values.
// ----------------------------------------------------------------------------
module tb_cmp_branch_sched;

  localparam int AW   = 16;
  localparam int SMAX = 4;

  logic clk;
  logic rst;

  cmp_branch_sched_if #(.AW(AW)) bif();

  cmp_branch_sched #(.AW(AW), .INT_STREAK_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_cmp;
  int n_err;
  int start_cnt;

  // Comparator model: register file per context and a flag bank per context.
  logic signed [15:0] regs [0:1][0:3];
  logic flag_lt [0:1];
  logic flag_gt [0:1];
  logic flag_eq [0:1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        flag_lt[k] <= 1'b0;
        flag_gt[k] <= 1'b0;
        flag_eq[k] <= 1'b0;
      end
    end else if (bif.cmp_start === 1'b1) begin
      flag_lt[bif.cmp_inter] <= regs[bif.cmp_inter][bif.cmp_num1] <  regs[bif.cmp_inter][bif.cmp_num2];
      flag_gt[bif.cmp_inter] <= regs[bif.cmp_inter][bif.cmp_num1] >  regs[bif.cmp_inter][bif.cmp_num2];
      flag_eq[bif.cmp_inter] <= regs[bif.cmp_inter][bif.cmp_num1] == regs[bif.cmp_inter][bif.cmp_num2];
    end
  end

  always @(posedge clk) begin
    if (bif.cmp_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  assign bif.cmp_lt = flag_lt[bif.cmp_inter];
  assign bif.cmp_gt = flag_gt[bif.cmp_inter];
  assign bif.cmp_eq = flag_eq[bif.cmp_inter];

  // Expected branch outcome straight from signed operand values.
  function automatic bit ref_taken(input logic [2:0] cond, input logic signed [15:0] a, input logic signed [15:0] b);
    case (cond)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return a <  b;
      3'd3:    return a >  b;
      3'd4:    return a <= b;
      3'd5:    return a >= b;
      3'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_bypass(input logic [2:0] cond);
`ifdef CMP_BYPASS_EN
    return cond >= 3'd6;
`else
    return (cond == 3'd0) && (cond != 3'd0);
`endif
  endfunction

  // One complete request from a single requester, checking timing and result.
  task automatic run_op(input bit ctx, input logic [1:0] a, input logic [1:0] b,
                        input logic [2:0] cond, input logic [15:0] tgt, input string tag);
    int cyc;
    bit seen;
    bit exp_taken;
    bit byp;
    int exp_lat;
    exp_taken = ref_taken(cond, regs[ctx][a], regs[ctx][b]);
    byp = is_bypass(cond);
    exp_lat = byp ? 0 : 2;
    if (ctx) begin
      bif.i_req = 1'b1; bif.i_num1 = a; bif.i_num2 = b; bif.i_cond = cond; bif.i_target = tgt;
    end else begin
      bif.n_req = 1'b1; bif.n_num1 = a; bif.n_num2 = b; bif.n_cond = cond; bif.n_target = tgt;
    end
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      seen = ctx ? (bif.i_ack === 1'b1) : (bif.n_ack === 1'b1);
    end
    bif.n_req = 1'b0;
    bif.i_req = 1'b0;
    n_cmp++;
    if (!seen || cyc != 1)
      $display("FAIL %s ack_latency: got %0d cycles (seen=%0d), want 1", tag, cyc, seen);
    if (!seen || cyc != 1) n_err++;
    n_cmp++;
    if (bif.cmp_start !== !byp || bif.cmp_inter !== ctx) begin
      $display("FAIL %s issue_drive: got start=%0b inter=%0b, want start=%0b inter=%0b",
               tag, bif.cmp_start, bif.cmp_inter, !byp, ctx);
      n_err++;
    end
    if (!byp) begin
      n_cmp++;
      if (bif.cmp_num1 !== a || bif.cmp_num2 !== b) begin
        $display("FAIL %s issue_sel: got %0d/%0d, want %0d/%0d", tag, bif.cmp_num1, bif.cmp_num2, a, b);
        n_err++;
      end
    end
    cyc = 0;
    seen = (bif.resp_valid === 1'b1);
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (!byp && cyc == 1) begin
        n_cmp++;
        if (bif.cmp_start !== 1'b0 || bif.cmp_inter !== ctx) begin
          $display("FAIL %s eval_drive: got start=%0b inter=%0b, want start=0 inter=%0b",
                   tag, bif.cmp_start, bif.cmp_inter, ctx);
          n_err++;
        end
      end
      seen = (bif.resp_valid === 1'b1);
    end
    n_cmp++;
    if (!seen || cyc != exp_lat) begin
      $display("FAIL %s resp_latency: got %0d after ack (seen=%0d), want %0d", tag, cyc, seen, exp_lat);
      n_err++;
    end
    n_cmp++;
    if (bif.resp_ctx !== ctx || bif.resp_taken !== exp_taken || bif.resp_target !== tgt) begin
      $display("FAIL %s resp: got ctx=%0b taken=%0b target=%h, want ctx=%0b taken=%0b target=%h",
               tag, bif.resp_ctx, bif.resp_taken, bif.resp_target, ctx, exp_taken, tgt);
      n_err++;
    end
    @(negedge clk);
    n_cmp++;
    if (bif.resp_valid !== 1'b0 || bif.busy !== 1'b0 || bif.cmp_inter !== 1'b0) begin
      $display("FAIL %s back_to_idle: got valid=%0b busy=%0b inter=%0b, want 0/0/0",
               tag, bif.resp_valid, bif.busy, bif.cmp_inter);
      n_err++;
    end
  endtask

  task automatic test_reset();
    logic [AW+13:0] outs;
    outs = {bif.n_ack, bif.i_ack, bif.cmp_start, bif.cmp_inter, bif.cmp_num1, bif.cmp_num2,
            bif.resp_valid, bif.resp_ctx, bif.resp_taken, bif.resp_target, bif.busy};
    n_cmp++;
    if (outs !== '0) begin
      $display("FAIL reset_outputs: got %h, want 0", outs);
      n_err++;
    end
  endtask

  task automatic test_basic_eq();
    regs[0][0] = 16'sd5;
    regs[0][1] = 16'sd5;
    run_op(1'b0, 2'd0, 2'd1, 3'd0, 16'hBEEF, "basic_eq");
  endtask

  task automatic test_signed();
    regs[1][2] = -16'sd2;
    regs[1][3] = 16'sd3;
    run_op(1'b1, 2'd2, 2'd3, 3'd2, 16'h1234, "signed_lt");
    run_op(1'b1, 2'd2, 2'd3, 3'd3, 16'h4321, "signed_gt");
  endtask

  task automatic test_cond_table();
    logic signed [15:0] pa [0:2];
    logic signed [15:0] pb [0:2];
    pa[0] = 16'sd4; pb[0] = 16'sd4;
    pa[1] = 16'sd1; pb[1] = 16'sd9;
    pa[2] = 16'sd9; pb[2] = 16'sd1;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 8; c++) begin
        regs[c % 2][1] = pa[p];
        regs[c % 2][2] = pb[p];
        run_op(1'(c % 2), 2'd1, 2'd2, 3'(c), 16'(p * 16 + c), "cond_table");
      end
    end
  endtask

  task automatic test_back_to_back();
    int grants;
    int resps;
    int cyc;
    int lastc;
    int stray;
    bit exp_n;
    bit tk_n;
    bit tk_i;
    bit q_ctx[$];
    bit q_tk[$];
    bit c;
    bit tk;
    regs[0][0] = 16'sd7;  regs[0][1] = 16'sd7;
    regs[1][2] = 16'sd10; regs[1][3] = -16'sd4;
    tk_n = ref_taken(3'd0, regs[0][0], regs[0][1]);
    tk_i = ref_taken(3'd2, regs[1][2], regs[1][3]);
    bif.n_num1 = 2'd0; bif.n_num2 = 2'd1; bif.n_cond = 3'd0; bif.n_target = 16'h00AA;
    bif.i_num1 = 2'd2; bif.i_num2 = 2'd3; bif.i_cond = 3'd2; bif.i_target = 16'h00BB;
    bif.n_req = 1'b1;
    bif.i_req = 1'b1;
    grants = 0; resps = 0; cyc = 0; lastc = 0;
    while (cyc < 80 && (grants < 10 || resps < grants)) begin
      @(negedge clk);
      cyc++;
      if (bif.n_ack === 1'b1 || bif.i_ack === 1'b1) begin
        exp_n = ((grants % (SMAX + 1)) == SMAX);
        n_cmp++;
        if (bif.n_ack !== exp_n || bif.i_ack !== !exp_n) begin
          $display("FAIL grant_order[%0d]: got n_ack=%0b i_ack=%0b, want n_ack=%0b i_ack=%0b",
                   grants, bif.n_ack, bif.i_ack, exp_n, !exp_n);
          n_err++;
        end
        q_ctx.push_back(!exp_n);
        q_tk.push_back(exp_n ? tk_n : tk_i);
        grants++;
        lastc = cyc;
        if (grants == 10) begin
          bif.n_req = 1'b0;
          bif.i_req = 1'b0;
        end
      end
      if (bif.resp_valid === 1'b1) begin
        n_cmp++;
        resps++;
        if (q_ctx.size() == 0) begin
          $display("FAIL extra_resp: got resp_valid with no pending grant, want none");
          n_err++;
        end else begin
          c  = q_ctx.pop_front();
          tk = q_tk.pop_front();
          if (cyc - lastc != 2 || bif.resp_ctx !== c || bif.resp_taken !== tk) begin
            $display("FAIL b2b_resp: got dist=%0d ctx=%0b taken=%0b, want dist=2 ctx=%0b taken=%0b",
                     cyc - lastc, bif.resp_ctx, bif.resp_taken, c, tk);
            n_err++;
          end
        end
      end
    end
    bif.n_req = 1'b0;
    bif.i_req = 1'b0;
    n_cmp++;
    if (grants != 10 || resps != 10) begin
      $display("FAIL b2b_counts: got grants=%0d resps=%0d, want 10/10", grants, resps);
      n_err++;
    end
    stray = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bif.n_ack === 1'b1 || bif.i_ack === 1'b1 || bif.resp_valid === 1'b1) stray++;
    end
    n_cmp++;
    if (stray != 0) begin
      $display("FAIL b2b_stray: got %0d extra ack/resp cycles, want 0", stray);
      n_err++;
    end
  endtask

  task automatic test_reset_mid_op();
    logic [AW+13:0] outs;
    int cyc;
    int stray;
    regs[0][0] = 16'sd3;
    regs[0][1] = 16'sd3;
    bif.n_req = 1'b1; bif.n_num1 = 2'd0; bif.n_num2 = 2'd1; bif.n_cond = 3'd0; bif.n_target = 16'h5555;
    cyc = 0;
    while (bif.n_ack !== 1'b1 && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    bif.n_req = 1'b0;
    n_cmp++;
    if (cyc != 1) begin
      $display("FAIL rstmid_ack: got ack after %0d cycles, want 1", cyc);
      n_err++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    outs = {bif.n_ack, bif.i_ack, bif.cmp_start, bif.cmp_inter, bif.cmp_num1, bif.cmp_num2,
            bif.resp_valid, bif.resp_ctx, bif.resp_taken, bif.resp_target, bif.busy};
    n_cmp++;
    if (outs !== '0) begin
      $display("FAIL rstmid_outputs: got %h, want 0", outs);
      n_err++;
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bif.resp_valid === 1'b1 || bif.busy === 1'b1) stray++;
    end
    n_cmp++;
    if (stray != 0) begin
      $display("FAIL rstmid_no_resp: got %0d active cycles, want 0", stray);
      n_err++;
    end
    run_op(1'b0, 2'd0, 2'd1, 3'd0, 16'h6666, "rstmid_after");
  endtask

  task automatic test_cond_always();
    int s0;
    s0 = start_cnt;
    regs[0][2] = 16'sd1;
    regs[0][3] = 16'sd2;
    run_op(1'b0, 2'd2, 2'd3, 3'd6, 16'hA5A5, "always");
    n_cmp++;
    if (start_cnt - s0 != (is_bypass(3'd6) ? 0 : 1)) begin
      $display("FAIL always_start_count: got %0d, want %0d", start_cnt - s0, is_bypass(3'd6) ? 0 : 1);
      n_err++;
    end
  endtask

  task automatic test_random();
    bit ctx;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] cond;
    for (int t = 0; t < 24; t++) begin
      ctx = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 1) == 0) regs[ctx][k] = 16'($urandom_range(0, 6)) - 16'sd3;
        else                           regs[ctx][k] = 16'($urandom);
      end
      a    = 2'($urandom_range(0, 3));
      b    = 2'($urandom_range(0, 3));
      cond = 3'($urandom_range(0, 7));
      run_op(ctx, a, b, cond, 16'($urandom), "random");
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    start_cnt = 0;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 4; k++) regs[c][k] = 16'sd0;
    rst = 1'b1;
    bif.n_req = 1'b0; bif.n_num1 = 2'd0; bif.n_num2 = 2'd0; bif.n_cond = 3'd0; bif.n_target = 16'd0;
    bif.i_req = 1'b0; bif.i_num1 = 2'd0; bif.i_num2 = 2'd0; bif.i_cond = 3'd0; bif.i_target = 16'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic_eq();
    test_signed();
    test_cond_table();
    test_back_to_back();
    test_reset_mid_op();
    test_cond_always();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
